// File: rtl/io_pad_ctrl_if.sv
// Wishbone pipelined bus bundle for io_pad_ctrl.
// The master drives request fields; the slave answers with ack, read data and stall.
interface io_pad_ctrl_if;
    logic [2:0]  wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_ack;
    logic        wb_stall;

    modport master (
        output wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb,
        input  wb_dat_r, wb_ack, wb_stall
    );

    modport slave (
        input  wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb,
        output wb_dat_r, wb_ack, wb_stall
    );
endinterface

// File: rtl/io_pad_ctrl.sv
// GPIO pad controller: Wishbone register file, push-pull/open-drain pad drive,
// synchronised and debounced inputs, edge-detect interrupts.
module io_pad_ctrl #(
    parameter int NUM_PINS    = 24,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    io_pad_ctrl_if.slave        wb,
    input  logic [NUM_PINS-1:0] pad_i,
    output logic [NUM_PINS-1:0] pad_o,
    output logic [NUM_PINS-1:0] pad_oe,
    output logic                irq_o
);
    localparam logic [2:0] ADR_IN   = 3'd0;
    localparam logic [2:0] ADR_OUT  = 3'd1;
    localparam logic [2:0] ADR_OE   = 3'd2;
    localparam logic [2:0] ADR_MODE = 3'd3;
    localparam logic [2:0] ADR_RISE = 3'd4;
    localparam logic [2:0] ADR_FALL = 3'd5;
    localparam logic [2:0] ADR_ISR  = 3'd6;
    localparam logic [2:0] ADR_DEB  = 3'd7;

    logic [NUM_PINS-1:0] out_q, out_d, oe_q, oe_d, mode_q, mode_d;
    logic [NUM_PINS-1:0] rise_q, rise_d, fall_q, fall_d, isr_q, isr_d;
    logic [DEBOUNCE_W-1:0] deb_q, deb_d;
    logic                  ack_q, ack_d, irq_q, irq_d;
    logic [31:0]           dat_r_q, dat_r_d;
    logic [NUM_PINS-1:0]   pad_o_q, pad_o_d, pad_oe_q, pad_oe_d;
    logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q, sync_d;
    logic [NUM_PINS-1:0]   stable_q, stable_d, stable_prev_q, stable_prev_d;
    logic [NUM_PINS-1:0][DEBOUNCE_W-1:0] cnt_q, cnt_d;

    logic                  req, wr_en, deb_wr;
    logic [31:0]           rd_mux, byte_mask, wdat_lanes, merged;
    logic [NUM_PINS-1:0]   sync_v, isr_clr, rise_hit, fall_hit;
    logic [DEBOUNCE_W-1:0] thr;
    logic                  unused_bits;

    // Handshake: stall is never raised, so every cycle with cyc&stb is a
    // transfer; it is acked (with read data) in the next cycle, and that ack
    // is withheld if the master has dropped cyc by then.
    assign req          = wb.wb_cyc & wb.wb_stb;
    assign wr_en        = req & wb.wb_we;
    assign wb.wb_stall  = 1'b0;
    assign wb.wb_ack    = ack_q & wb.wb_cyc;
    assign wb.wb_dat_r  = dat_r_q;
    assign pad_o        = pad_o_q;
    assign pad_oe       = pad_oe_q;
    assign irq_o        = irq_q;

    assign byte_mask  = {{8{wb.wb_sel[3]}}, {8{wb.wb_sel[2]}},
                         {8{wb.wb_sel[1]}}, {8{wb.wb_sel[0]}}};
    assign wdat_lanes = wb.wb_dat_w & byte_mask;
    assign merged     = (rd_mux & ~byte_mask) | wdat_lanes;
    assign sync_v     = sync_q[SYNC_STAGES-1];
    assign thr        = (deb_q == '0) ? DEBOUNCE_W'(1) : deb_q;
    assign rise_hit   = stable_q & ~stable_prev_q & rise_q;
    assign fall_hit   = ~stable_q & stable_prev_q & fall_q;
    assign unused_bits = ^{merged, wdat_lanes};

    always_comb begin
        rd_mux = '0;
        case (wb.wb_adr)
            ADR_IN:   rd_mux = 32'(stable_q);
            ADR_OUT:  rd_mux = 32'(out_q);
            ADR_OE:   rd_mux = 32'(oe_q);
            ADR_MODE: rd_mux = 32'(mode_q);
            ADR_RISE: rd_mux = 32'(rise_q);
            ADR_FALL: rd_mux = 32'(fall_q);
            ADR_ISR:  rd_mux = 32'(isr_q);
            ADR_DEB:  rd_mux = 32'(deb_q);
            default:  rd_mux = '0;
        endcase
    end

    always_comb begin
        out_d   = out_q;
        oe_d    = oe_q;
        mode_d  = mode_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        deb_d   = deb_q;
        deb_wr  = 1'b0;
        isr_clr = '0;
        if (wr_en) begin
            case (wb.wb_adr)
                ADR_OUT:  out_d  = merged[NUM_PINS-1:0];
                ADR_OE:   oe_d   = merged[NUM_PINS-1:0];
                ADR_MODE: mode_d = merged[NUM_PINS-1:0];
                ADR_RISE: rise_d = merged[NUM_PINS-1:0];
                ADR_FALL: fall_d = merged[NUM_PINS-1:0];
                ADR_ISR:  isr_clr = wdat_lanes[NUM_PINS-1:0];
                ADR_DEB: begin
                    deb_d  = merged[DEBOUNCE_W-1:0];
                    deb_wr = 1'b1;
                end
                default: ;
            endcase
        end
        // New edges win over a simultaneous W1C so no event is lost.
        isr_d   = (isr_q & ~isr_clr) | rise_hit | fall_hit;
        irq_d   = |isr_q;
        ack_d   = req;
        dat_r_d = (req && !wb.wb_we) ? rd_mux : 32'd0;
        pad_o_d  = out_q & ~mode_q;
        pad_oe_d = (mode_q & ~out_q) | (~mode_q & oe_q);
    end

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = pad_i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        cnt_d         = cnt_q;
        for (int i = 0; i < NUM_PINS; i++) begin
            if (deb_wr || (sync_v[i] == stable_q[i])) begin
                cnt_d[i] = '0;
            end else if ((cnt_q[i] + DEBOUNCE_W'(1)) == thr) begin
                stable_d[i] = sync_v[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DEBOUNCE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q         <= '0;
            oe_q          <= '0;
            mode_q        <= '0;
            rise_q        <= '0;
            fall_q        <= '0;
            isr_q         <= '0;
            deb_q         <= '0;
            ack_q         <= 1'b0;
            irq_q         <= 1'b0;
            dat_r_q       <= '0;
            pad_o_q       <= '0;
            pad_oe_q      <= '0;
            sync_q        <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            cnt_q         <= '0;
        end else begin
            out_q         <= out_d;
            oe_q          <= oe_d;
            mode_q        <= mode_d;
            rise_q        <= rise_d;
            fall_q        <= fall_d;
            isr_q         <= isr_d;
            deb_q         <= deb_d;
            ack_q         <= ack_d;
            irq_q         <= irq_d;
            dat_r_q       <= dat_r_d;
            pad_o_q       <= pad_o_d;
            pad_oe_q      <= pad_oe_d;
            sync_q        <= sync_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            cnt_q         <= cnt_d;
        end
    end
endmodule

// File: doc/io_pad_ctrl.md
IO_PAD_CTRL -- requirements
Module: io_pad_ctrl

Interface
REQ-001 Parameter NUM_PINS, default 24, number of pad channels (legal range 1..32).
REQ-002 Parameter SYNC_STAGES, default 2, input synchronizer depth (legal range 2..3).
REQ-003 Parameter DEBOUNCE_W, default 8, per-pin debounce counter width (legal range 1..16).
REQ-004 Port: clk  in  1  single clock; all logic in this domain.
REQ-005 Port: rst  in  1  asynchronous, active-high reset.
REQ-006 Ports: wb_adr in 3 (word address), wb_dat_w in 32, wb_dat_r out 32, wb_sel in 4, wb_we in 1, wb_cyc in 1, wb_stb in 1, wb_ack out 1, wb_stall out 1; Wishbone pipelined slave.
REQ-007 Ports: pad_i in NUM_PINS (raw pad input), pad_o out NUM_PINS (pad output value), pad_oe out NUM_PINS (1 = drive pad).
REQ-008 Port: irq_o  out  1  level interrupt, high while any enabled edge is pending.

Function
REQ-009 Register map (word offset): 0 IN (RO), 1 OUT, 2 OE, 3 MODE (1 = open-drain), 4 RISE_EN, 5 FALL_EN, 6 ISR (W1C), 7 DEBOUNCE (bits DEBOUNCE_W-1:0, threshold T).
REQ-010 Bits at or above NUM_PINS, and DEBOUNCE bits at or above DEBOUNCE_W: read 0, writes ignored.
REQ-011 wb_stall is tied to 0; wb_ack asserts exactly one cycle after each cycle with wb_cyc&wb_stb; wb_dat_r is valid in the wb_ack cycle.
REQ-012 Writes take effect on the wb_ack edge and honour wb_sel per byte lane; writes to IN are ignored.
REQ-013 If wb_cyc deasserts with an ack outstanding, the ack is dropped (wb_ack = 0 the next cycle).
REQ-014 Push-pull pin (MODE=0): pad_oe = OE, pad_o = OUT.
REQ-015 Open-drain pin (MODE=1): pad_o = 0, pad_oe = ~OUT, and OE is ignored.
REQ-016 pad_o and pad_oe are registered and update one cycle after the register write takes effect.
REQ-017 pad_i passes a SYNC_STAGES-flop synchronizer per pin, giving sync.
REQ-018 Per-pin debounce counter behaviour, cycle by cycle:
- sync == stable -> counter cleared.
- sync != stable -> counter increments.
- when the count reaches T, stable <= sync and counter cleared.
REQ-019 T = 0 and T = 1 both mean no filtering: stable follows sync with one cycle of delay.
REQ-020 Counter saturation cannot occur because T <= 2^DEBOUNCE_W-1.
REQ-021 Writing a new T clears all counters and does not change stable.
REQ-022 IN reads the stable vector.
REQ-023 Edge detect on stable: a 0->1 transition with RISE_EN set, or a 1->0 transition with FALL_EN set, sets the ISR bit on the following edge.
REQ-024 An ISR bit is cleared by writing 1 to it; a set and a clear in the same cycle leave the bit set.
REQ-025 Clearing an enable bit does not clear an already pending ISR bit.
REQ-026 irq_o = registered OR of the ISR bits, asserting one cycle after an ISR bit sets.
REQ-027 Latency from a pad_i change to an IN change is SYNC_STAGES + max(T,1) cycles; ISR/irq_o follow 1 and 2 cycles later respectively.

Reset
REQ-028 While rst is high, all of the following are 0:
- registers, sync flops, stable, counters, ISR.
- wb_ack, wb_dat_r, pad_o, pad_oe, irq_o.
REQ-029 Reset asserted mid-transaction aborts it and no ack is issued.
REQ-030 No edge is recorded after reset release because RISE_EN and FALL_EN are 0.

Verification
REQ-031 Write OUT=0x5, OE=0x3 (MODE=0) -> after ack+1 cycle, pad_oe=0x3, pad_o=0x5; read OE returns 0x3 with ack one cycle after stb.
REQ-032 MODE=0x1, OUT bit0 toggles 0->1 -> pad_o[0]=0 throughout; pad_oe[0] goes 1->0; OE bit0 has no effect.
REQ-033 T=4, pad_i[2] pulses high for 3 cycles -> IN[2] stays 0; a pulse held 6 cycles -> IN[2]=1 exactly SYNC_STAGES+4 cycles after the rise.
REQ-034 RISE_EN=0x4, T=0, pad_i[2] rises -> ISR=0x4 and irq_o=1; write ISR=0x4 -> ISR=0, irq_o=0 next cycle; a new edge coincident with the W1C write leaves ISR=0x4.
REQ-035 rst pulsed with stb pending and pad_oe=0xFFFFFF -> all outputs 0 immediately (asynchronously), no ack, and IN=0 until pad_i resynchronizes.
